// File: rtl/uart_program_loader.sv
// Boot loader: assembles little-endian 32-bit words from a UART byte stream,
// writes them to the instruction ROM and holds the CPU in reset until done.
module uart_program_loader #(
    parameter int ROM_ADDRESS_BITWIDTH = 10
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            rx_valid,
    input  logic [7:0]                      rx_data,
    output logic                            rom_wren,
    output logic [ROM_ADDRESS_BITWIDTH-1:0] rom_address,
    output logic [31:0]                     rom_write_data,
    output logic                            cpu_reset_n,
    output logic                            loading,
    output logic                            error,
    output logic [31:0]                     checksum
);

    localparam int AW  = ROM_ADDRESS_BITWIDTH;
    localparam int WCW = AW - 1;
    localparam int unsigned DEPTH = 2 ** (AW - 2);

    typedef enum logic [2:0] {
        S_RECV_LEN,
        S_LOAD,
        S_FLUSH,
        S_DONE,
        S_ERROR
    } state_t;

    state_t          r_state;
    logic [1:0]      r_byte_cnt;
    logic [WCW-1:0]  r_word_cnt;
    logic [31:0]     r_len;
    logic [31:0]     r_word;
    logic            r_wren;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_data;
    logic [31:0]     r_checksum;
    logic            r_cpu_reset_n;
    logic            r_loading;
    logic            r_error;

    // Bytes arrive least-significant first, so shifting in from the top
    // leaves byte k at bits [8k+7:8k] after four bytes.
    logic [31:0] w_len_next;
    logic [31:0] w_word_next;
    logic        w_last_word;

    assign w_len_next  = {rx_data, r_len[31:8]};
    assign w_word_next = {rx_data, r_word[31:8]};
    assign w_last_word = (32'(r_word_cnt) == (r_len - 32'd1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_RECV_LEN;
            r_byte_cnt    <= 2'd0;
            r_word_cnt    <= '0;
            r_len         <= 32'd0;
            r_word        <= 32'd0;
            r_wren        <= 1'b0;
            r_addr        <= '0;
            r_data        <= 32'd0;
            r_checksum    <= 32'd0;
            r_cpu_reset_n <= 1'b0;
            r_loading     <= 1'b1;
            r_error       <= 1'b0;
        end else begin
            r_wren <= 1'b0;
            case (r_state)
                S_RECV_LEN: begin
                    if (rx_valid) begin
                        r_len      <= w_len_next;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            if (w_len_next == 32'd0) begin
                                r_state <= S_DONE;
                            end else if (w_len_next > 32'(DEPTH)) begin
                                r_state   <= S_ERROR;
                                r_error   <= 1'b1;
                                r_loading <= 1'b0;
                            end else begin
                                r_state <= S_LOAD;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    if (rx_valid) begin
                        r_word     <= w_word_next;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_wren     <= 1'b1;
                            r_addr     <= {r_word_cnt[AW-3:0], 2'b00};
                            r_data     <= w_word_next;
                            r_checksum <= r_checksum + w_word_next;
                            r_word_cnt <= r_word_cnt + {{(WCW-1){1'b0}}, 1'b1};
                            if (w_last_word) begin
                                r_state <= S_FLUSH;
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    r_state <= S_DONE;
                end
                // Release is registered one cycle after entering DONE.
                S_DONE: begin
                    r_cpu_reset_n <= 1'b1;
                    r_loading     <= 1'b0;
                end
                S_ERROR: begin
                    r_error <= 1'b1;
                end
                default: begin
                    r_state <= S_ERROR;
                end
            endcase
        end
    end

    assign rom_wren       = r_wren;
    assign rom_address    = r_addr;
    assign rom_write_data = r_data;
    assign checksum       = r_checksum;
    assign cpu_reset_n    = r_cpu_reset_n;
    assign loading        = r_loading;
    assign error          = r_error;

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader: directed scenarios with
// random payloads compared against a queue-based model of the ROM writes.
module tb_uart_program_loader;

    localparam int AW = 10;
    localparam int DEPTH = 2 ** (AW - 2);

    logic          clk;
    logic          reset_n;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rom_wren;
    logic [AW-1:0] rom_address;
    logic [31:0]   rom_write_data;
    logic          cpu_reset_n;
    logic          loading;
    logic          error;
    logic [31:0]   checksum;

    int errors = 0;
    int checks = 0;

    logic [31:0] progWords[$];
    logic [31:0] obsAddr[$];
    logic [31:0] obsData[$];
    int          doubleWren = 0;
    logic        prevWren = 1'b0;

    uart_program_loader #(.ROM_ADDRESS_BITWIDTH(AW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rom_wren       (rom_wren),
        .rom_address    (rom_address),
        .rom_write_data (rom_write_data),
        .cpu_reset_n    (cpu_reset_n),
        .loading        (loading),
        .error          (error),
        .checksum       (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every ROM write as seen away from the active edge.
    always @(negedge clk) begin
        if (rom_wren === 1'b1) begin
            obsAddr.push_back(32'(rom_address));
            obsData.push_back(rom_write_data);
            if (prevWren === 1'b1) doubleWren++;
        end
        prevWren <= rom_wren;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        obsAddr.delete();
        obsData.delete();
    endtask

    task automatic sendHeader(input logic [31:0] n, input int maxGap);
        for (int k = 0; k < 4; k++)
            applyStimulus(n[8*k +: 8], (maxGap > 0) ? $urandom_range(maxGap, 0) : 0);
    endtask

    task automatic sendWords(input int maxGap);
        logic [31:0] w;
        for (int i = 0; i < progWords.size(); i++) begin
            w = progWords[i];
            for (int k = 0; k < 4; k++)
                applyStimulus(w[8*k +: 8], (maxGap > 0) ? $urandom_range(maxGap, 0) : 0);
        end
    endtask

    task automatic randomWords(input int n);
        progWords.delete();
        for (int i = 0; i < n; i++) progWords.push_back($urandom);
    endtask

    task automatic waitDone();
        int k = 0;
        while (cpu_reset_n !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
    endtask

    // Model: word i lands at byte address 4*i; checksum is the plain 32-bit sum.
    task automatic checkWrites(input string tag);
        logic [31:0] sum = 32'd0;
        int n = progWords.size();
        int m;
        foreach (progWords[i]) sum += progWords[i];
        checkOutput({tag, ".count"}, 32'(obsAddr.size()), 32'(n));
        m = (obsAddr.size() < n) ? obsAddr.size() : n;
        for (int i = 0; i < m; i++) begin
            checkOutput($sformatf("%s.addr%0d", tag, i), obsAddr[i], 32'(i * 4));
            checkOutput($sformatf("%s.data%0d", tag, i), obsData[i], progWords[i]);
        end
        checkOutput({tag, ".checksum"}, checksum, sum);
        checkOutput({tag, ".cpuRel"}, 32'(cpu_reset_n), 32'd1);
        checkOutput({tag, ".loading"}, 32'(loading), 32'd0);
        checkOutput({tag, ".error"}, 32'(error), 32'd0);
    endtask

    initial begin
        logic [31:0] savedSum;
        logic [31:0] savedAddr;
        logic [31:0] savedData;
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // Reset state
        doReset();
        checkOutput("rst.wren", 32'(rom_wren), 32'd0);
        checkOutput("rst.addr", 32'(rom_address), 32'd0);
        checkOutput("rst.data", rom_write_data, 32'd0);
        checkOutput("rst.checksum", checksum, 32'd0);
        checkOutput("rst.error", 32'(error), 32'd0);
        checkOutput("rst.cpuRst", 32'(cpu_reset_n), 32'd0);
        checkOutput("rst.loading", 32'(loading), 32'd1);

        // Basic single-word load with exact release timing
        progWords.delete();
        progWords.push_back(32'h00100513);
        sendHeader(32'd1, 0);
        sendWords(0);
        checkOutput("basic.wrenE", 32'(rom_wren), 32'd1);
        checkOutput("basic.cpuE", 32'(cpu_reset_n), 32'd0);
        @(negedge clk);
        checkOutput("basic.wrenE1", 32'(rom_wren), 32'd0);
        checkOutput("basic.cpuE1", 32'(cpu_reset_n), 32'd0);
        @(negedge clk);
        checkOutput("basic.cpuE2", 32'(cpu_reset_n), 32'd1);
        checkWrites("basic");

        // Three words with gapped bytes
        doReset();
        progWords.delete();
        progWords.push_back(32'h11111111);
        progWords.push_back(32'h22222222);
        progWords.push_back(32'h33333333);
        sendHeader(32'd3, 5);
        sendWords(5);
        waitDone();
        checkWrites("gapped");
        checkOutput("gapped.sumConst", checksum, 32'h66666666);

        // Back-to-back bytes, rx_valid high for 12 cycles
        doReset();
        randomWords(2);
        sendHeader(32'd2, 0);
        sendWords(0);
        waitDone();
        checkWrites("b2b");

        // N == 0
        doReset();
        progWords.delete();
        sendHeader(32'd0, 0);
        checkOutput("zero.cpuL", 32'(cpu_reset_n), 32'd0);
        @(negedge clk);
        checkOutput("zero.cpuL1", 32'(cpu_reset_n), 32'd1);
        checkWrites("zero");

        // N == DEPTH
        doReset();
        randomWords(DEPTH);
        sendHeader(32'(DEPTH), 0);
        sendWords(0);
        waitDone();
        checkWrites("full");
        checkOutput("full.lastAddr", 32'(rom_address), 32'h3FC);

        // N == DEPTH+1 is rejected and further bytes ignored
        doReset();
        sendHeader(32'(DEPTH + 1), 0);
        checkOutput("over.error", 32'(error), 32'd1);
        checkOutput("over.loading", 32'(loading), 32'd0);
        for (int i = 0; i < 12; i++) applyStimulus(8'($urandom), 0);
        repeat (3) @(negedge clk);
        checkOutput("over.errorSticky", 32'(error), 32'd1);
        checkOutput("over.cpuRst", 32'(cpu_reset_n), 32'd0);
        checkOutput("over.count", 32'(obsAddr.size()), 32'd0);

        // Reset in the middle of an N=2 load, then reload
        doReset();
        randomWords(2);
        sendHeader(32'd2, 0);
        for (int k = 0; k < 6; k++) applyStimulus(progWords[k / 4][8*(k % 4) +: 8], 1);
        doReset();
        checkOutput("midRst.checksum", checksum, 32'd0);
        checkOutput("midRst.cpuRst", 32'(cpu_reset_n), 32'd0);
        sendHeader(32'd2, 2);
        checkOutput("midRst.cpuHdr", 32'(cpu_reset_n), 32'd0);
        sendWords(2);
        waitDone();
        checkWrites("midRst");

        // Traffic after DONE is ignored
        savedSum  = checksum;
        savedAddr = 32'(rom_address);
        savedData = rom_write_data;
        for (int i = 0; i < 8; i++) applyStimulus(8'($urandom), 0);
        repeat (3) @(negedge clk);
        checkOutput("post.count", 32'(obsAddr.size()), 32'd2);
        checkOutput("post.checksum", checksum, savedSum);
        checkOutput("post.addr", 32'(rom_address), savedAddr);
        checkOutput("post.data", rom_write_data, savedData);
        checkOutput("post.cpuRel", 32'(cpu_reset_n), 32'd1);

        checkOutput("noDoubleWren", 32'(doubleWren), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
